// File: rtl/divisor_multiciclo_if.sv
// Operand/result bundle between the control unit and the multicycle divider.
// DivSigned exists only when DIVISOR_DIVU_EN is defined.
interface divisor_multiciclo_if #(
  parameter int WIDTH = 32
) ();
  logic             DivCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivDone;
  logic             DivZero;
  logic             DivBusy;
`ifdef DIVISOR_DIVU_EN
  logic             DivSigned;

  modport master (
    output DivCtrl, A, B, DivSigned,
    input  HI, LO, DivDone, DivZero, DivBusy
  );
  modport slave (
    input  DivCtrl, A, B, DivSigned,
    output HI, LO, DivDone, DivZero, DivBusy
  );
`else
  modport master (
    output DivCtrl, A, B,
    input  HI, LO, DivDone, DivZero, DivBusy
  );
  modport slave (
    input  DivCtrl, A, B,
    output HI, LO, DivDone, DivZero, DivBusy
  );
`endif
endinterface

// File: rtl/divisor_multiciclo.sv
// Restoring shift-subtract divider, one quotient bit per cycle (DIV, HI/LO).
// Optional macro DIVISOR_DIVU_EN adds DivSigned to select unsigned DIVU.
module divisor_multiciclo #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  divisor_multiciclo_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    DONE,
    ZERO
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   r_sh;

`ifdef DIVISOR_DIVU_EN
  assign sgn_in = bus.DivSigned;
`else
  assign sgn_in = 1'b1;
`endif

  assign a_neg = sgn_in & bus.A[WIDTH-1];
  assign b_neg = sgn_in & bus.B[WIDTH-1];
  assign mag_a = a_neg ? -bus.A : bus.A;
  assign mag_b = b_neg ? -bus.B : bus.B;

  // Partial remainder is one bit wider only for the shift/compare.
  assign r_sh = {r_q, q_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.DivCtrl) begin
          state_d = (bus.B == '0) ? ZERO : CALC;
          cnt_d   = '0;
          r_d     = '0;
          q_d     = mag_a;
          b_d     = mag_b;
          sa_d    = a_neg;
          sb_d    = b_neg;
        end
      end
      CALC: begin
        if (r_sh >= {1'b0, b_q}) begin
          r_d = WIDTH'(r_sh - {1'b0, b_q});
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_sh[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
        hi_d    = sa_q ? -r_q : r_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.DivDone = (state_q == DONE);
  assign bus.DivZero = (state_q == ZERO);
  assign bus.DivBusy = (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_divisor_multiciclo.sv
// Self-checking bench for divisor_multiciclo against a plain-arithmetic model.
// DivSigned stimulus is driven only when DIVISOR_DIVU_EN is defined.
module tb_divisor_multiciclo;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  divisor_multiciclo_if #(.WIDTH(32)) bus ();

  divisor_multiciclo #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          sgn,
    output logic [31:0] q,
    output logic [31:0] r
  );
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic set_sgn(input bit sgn);
`ifdef DIVISOR_DIVU_EN
    bus.DivSigned = sgn;
`else
    if (!sgn) $display("note: unsigned request ignored in signed-only build");
`endif
  endtask

  task automatic do_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          sgn,
    output int          done_cyc,
    output int          done_n,
    output int          zero_cyc,
    output int          zero_n,
    output int          busy_bad
  );
    bit exp_busy;
    bus.A       = a;
    bus.B       = b;
    set_sgn(sgn);
    bus.DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    bus.DivCtrl = 1'b0;
    done_cyc = -1;
    zero_cyc = -1;
    done_n   = 0;
    zero_n   = 0;
    busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      exp_busy = (b != 0) && (c <= 33);
      if (bus.DivBusy !== exp_busy) busy_bad++;
      if (bus.DivDone === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.DivZero === 1'b1) begin
        zero_n++;
        if (zero_cyc < 0) zero_cyc = c;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_op(
    input string       name,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          sgn
  );
    logic [31:0] eq;
    logic [31:0] er;
    int dc, dn, zc, zn, bb;
    model(a, b, sgn, eq, er);
    do_op(a, b, sgn, dc, dn, zc, zn, bb);
    checks++;
    if (bus.LO !== eq) begin
      errors++;
      $display("FAIL %s LO: got %h want %h", name, bus.LO, eq);
    end
    checks++;
    if (bus.HI !== er) begin
      errors++;
      $display("FAIL %s HI: got %h want %h", name, bus.HI, er);
    end
    checks++;
    if (dc !== 34 || dn !== 1 || zn !== 0) begin
      errors++;
      $display("FAIL %s done: cyc %0d n %0d zero %0d want 34/1/0",
               name, dc, dn, zn);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL %s busy: %0d bad cycles want 0", name, bb);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.DivCtrl = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    set_sgn(1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.HI, bus.LO} !== 64'h0 ||
        {bus.DivDone, bus.DivZero, bus.DivBusy} !== 3'b000) begin
      errors++;
      $display("FAIL reset: HI %h LO %h flags %b want 0", bus.HI, bus.LO,
               {bus.DivDone, bus.DivZero, bus.DivBusy});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    check_op("7/2", 32'd7, 32'd2, 1'b1);
    check_op("-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_op("7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    check_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (bus.LO !== 32'h8000_0000 || bus.HI !== 32'h0) begin
      errors++;
      $display("FAIL ovf const: LO %h HI %h want 80000000/0", bus.LO, bus.HI);
    end
    check_op("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
  endtask

  task automatic test_zero();
    int dc, dn, zc, zn, bb;
    check_op("prep", 32'h451, 32'h20, 1'b1);
    do_op(32'd5, 32'd0, 1'b1, dc, dn, zc, zn, bb);
    checks++;
    if (zc !== 1 || zn !== 1) begin
      errors++;
      $display("FAIL zero pulse: cyc %0d n %0d want 1/1", zc, zn);
    end
    checks++;
    if (dn !== 0 || bb !== 0) begin
      errors++;
      $display("FAIL zero done/busy: done %0d busy %0d want 0/0", dn, bb);
    end
    checks++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      errors++;
      $display("FAIL zero hold: HI %h LO %h want 11/22", bus.HI, bus.LO);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] prev_lo;
    int dc;
    prev_lo     = bus.LO;
    bus.A       = 32'd100;
    bus.B       = 32'd7;
    bus.DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    bus.DivCtrl = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 9) begin
        bus.A       = 32'd1;
        bus.B       = 32'd1;
        bus.DivCtrl = 1'b1;
      end
      if (c == 10) bus.DivCtrl = 1'b0;
      if (c == 20) begin
        checks++;
        if (bus.LO !== prev_lo) begin
          errors++;
          $display("FAIL ignore hold: LO %h want %h", bus.LO, prev_lo);
        end
      end
      if (bus.DivDone === 1'b1 && dc < 0) dc = c;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.LO !== 32'd14 || bus.HI !== 32'd2 || dc !== 34) begin
      errors++;
      $display("FAIL ignore: LO %0d HI %0d done %0d want 14/2/34",
               bus.LO, bus.HI, dc);
    end
  endtask

  task automatic test_reset_mid();
    bus.A       = 32'd100;
    bus.B       = 32'd7;
    bus.DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    bus.DivCtrl = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({bus.HI, bus.LO} !== 64'h0 ||
        {bus.DivDone, bus.DivZero, bus.DivBusy} !== 3'b000) begin
      errors++;
      $display("FAIL reset mid: HI %h LO %h flags %b want 0", bus.HI, bus.LO,
               {bus.DivDone, bus.DivZero, bus.DivBusy});
    end
    check_op("after rst", 32'd50, 32'd6, 1'b1);
  endtask

  task automatic test_back_to_back();
    int d1, d2, dn;
    bit gap_ok;
    bus.A       = 32'd1000;
    bus.B       = 32'd3;
    bus.DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    d1 = -1;
    d2 = -1;
    dn = 0;
    gap_ok = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      if (c == 35) gap_ok = (bus.DivBusy === 1'b0);
      if (bus.DivDone === 1'b1) begin
        dn++;
        if (d1 < 0) begin
          d1 = c;
          checks++;
          if (bus.LO !== 32'd333 || bus.HI !== 32'd1) begin
            errors++;
            $display("FAIL b2b first: LO %0d HI %0d want 333/1",
                     bus.LO, bus.HI);
          end
          bus.A = 32'd9;
          bus.B = 32'd2;
        end else if (d2 < 0) begin
          d2 = c;
        end
      end
      if (c == 69) bus.DivCtrl = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (d1 !== 34 || d2 !== 69 || dn !== 2 || !gap_ok) begin
      errors++;
      $display("FAIL b2b timing: d1 %0d d2 %0d n %0d gap %0b want 34/69/2/1",
               d1, d2, dn, gap_ok);
    end
    checks++;
    if (bus.LO !== 32'd4 || bus.HI !== 32'd1) begin
      errors++;
      $display("FAIL b2b second: LO %0d HI %0d want 4/1", bus.LO, bus.HI);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = -$urandom_range(1, 255);
        default: b = $urandom_range(1, 65535);
      endcase
      if (b == 0) b = 32'd1;
      check_op($sformatf("rnd%0d", i), a, b, 1'b1);
    end
  endtask

`ifdef DIVISOR_DIVU_EN
  task automatic test_divu();
    check_op("divu", 32'hFFFF_FFFE, 32'd2, 1'b0);
    checks++;
    if (bus.LO !== 32'h7FFF_FFFF || bus.HI !== 32'h0) begin
      errors++;
      $display("FAIL divu const: LO %h HI %h want 7fffffff/0", bus.LO, bus.HI);
    end
    check_op("div same", 32'hFFFF_FFFE, 32'd2, 1'b1);
    checks++;
    if (bus.LO !== 32'hFFFF_FFFF || bus.HI !== 32'h0) begin
      errors++;
      $display("FAIL div const: LO %h HI %h want ffffffff/0", bus.LO, bus.HI);
    end
    for (int i = 0; i < 8; i++) begin
      check_op($sformatf("urnd%0d", i), $urandom, $urandom_range(1, 32'hFFFF_FFFF), 1'b0);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_zero();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef DIVISOR_DIVU_EN
    test_divu();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
